// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I sequencer: walks IF/ID/EX/MEM/WB one micro-step per cycle,
// driving the shared ALU, unified memory, IR, PC and register-file strobes.
module multi_cycle_control_unit #(
   parameter int INSTRET_WIDTH = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [6:0]               opcode_i,
   input  logic                     mem_ready_i,
   input  logic                     bcond_i,
   input  logic                     halt_req_i,
   output logic                     pc_write_o,
   output logic                     pc_write_cond_o,
   output logic                     pc_source_o,
   output logic                     i_or_d_o,
   output logic                     mem_read_o,
   output logic                     mem_write_o,
   output logic                     ir_write_o,
   output logic                     mem_to_reg_o,
   output logic                     reg_write_o,
   output logic                     alu_src_a_o,
   output logic [1:0]               alu_src_b_o,
   output logic [1:0]               alu_op_o,
   output logic                     is_ecall_o,
   output logic                     halted_o,
   output logic [INSTRET_WIDTH-1:0] instret_o
);

   localparam logic [6:0] OP_JAL       = 7'b1101111;
   localparam logic [6:0] OP_JALR      = 7'b1100111;
   localparam logic [6:0] OP_BRANCH    = 7'b1100011;
   localparam logic [6:0] OP_LOAD      = 7'b0000011;
   localparam logic [6:0] OP_STORE     = 7'b0100011;
   localparam logic [6:0] OP_ARITH     = 7'b0110011;
   localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
   localparam logic [6:0] OP_ECALL     = 7'b1110011;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_FOUR = 2'b01;
   localparam logic [1:0] SRC_B_IMM  = 2'b10;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_BRANCH = 2'b01;
   localparam logic [1:0] ALU_FUNCT  = 2'b10;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_e;

   state_e                   state_q, state_d;
   logic [INSTRET_WIDTH-1:0] instret_q;
   logic                     retire;

   logic is_jal, is_jalr, is_branch, is_load, is_store;
   logic is_arith, is_arith_imm, is_ecall_op, is_nop;

   always_comb begin
      is_jal       = (opcode_i == OP_JAL);
      is_jalr      = (opcode_i == OP_JALR);
      is_branch    = (opcode_i == OP_BRANCH);
      is_load      = (opcode_i == OP_LOAD);
      is_store     = (opcode_i == OP_STORE);
      is_arith     = (opcode_i == OP_ARITH);
      is_arith_imm = (opcode_i == OP_ARITH_IMM);
      is_ecall_op  = (opcode_i == OP_ECALL);
      is_nop       = !(is_jal || is_jalr || is_branch || is_load || is_store ||
                       is_arith || is_arith_imm || is_ecall_op);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IF;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire) begin
            instret_q <= instret_q + INSTRET_WIDTH'(1);
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      retire          = 1'b0;
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      pc_source_o     = 1'b0;
      i_or_d_o        = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      ir_write_o      = 1'b0;
      mem_to_reg_o    = 1'b0;
      reg_write_o     = 1'b0;
      alu_src_a_o     = 1'b0;
      alu_src_b_o     = SRC_B_RS2;
      alu_op_o        = ALU_ADD;
      is_ecall_o      = 1'b0;
      halted_o        = 1'b0;

      unique case (state_q)
         S_IF: begin
            mem_read_o = 1'b1;
            if (mem_ready_i) begin
               ir_write_o = 1'b1;
               state_d    = S_ID;
            end
         end

         S_ID: begin
            // ALUOut captures PC+imm here for later branch/jump targets
            alu_src_b_o = SRC_B_IMM;
            alu_op_o    = ALU_ADD;
            if (is_ecall_op) begin
               is_ecall_o = 1'b1;
               state_d    = halt_req_i ? S_HALT : S_WB;
            end else if (is_nop) begin
               state_d = S_WB;
            end else begin
               state_d = S_EX;
            end
         end

         S_EX: begin
            if (is_arith || is_arith_imm) begin
               alu_src_a_o = 1'b1;
               alu_src_b_o = is_arith_imm ? SRC_B_IMM : SRC_B_RS2;
               alu_op_o    = ALU_FUNCT;
               state_d     = S_WB;
            end else if (is_load || is_store || is_jalr) begin
               alu_src_a_o = 1'b1;
               alu_src_b_o = SRC_B_IMM;
               state_d     = is_jalr ? S_WB : S_MEM;
            end else if (is_branch) begin
               alu_src_a_o     = 1'b1;
               alu_op_o        = ALU_BRANCH;
               pc_write_cond_o = 1'b1;
               pc_source_o     = 1'b1;
               if (bcond_i) begin
                  retire  = 1'b1;
                  state_d = S_IF;
               end else begin
                  state_d = S_WB;
               end
            end else if (is_jal) begin
               // link PC+4 into rd while the PC loads the ALUOut target
               alu_src_b_o = SRC_B_FOUR;
               reg_write_o = 1'b1;
               pc_write_o  = 1'b1;
               pc_source_o = 1'b1;
               retire      = 1'b1;
               state_d     = S_IF;
            end else begin
               state_d = S_WB;
            end
         end

         S_MEM: begin
            i_or_d_o = 1'b1;
            if (is_store) begin
               mem_write_o = 1'b1;
               if (mem_ready_i) begin
                  alu_src_b_o = SRC_B_FOUR;
                  pc_write_o  = 1'b1;
                  retire      = 1'b1;
                  state_d     = S_IF;
               end
            end else begin
               mem_read_o = 1'b1;
               if (mem_ready_i) begin
                  state_d = S_WB;
               end
            end
         end

         S_WB: begin
            alu_src_b_o  = SRC_B_FOUR;
            pc_write_o   = 1'b1;
            pc_source_o  = is_jalr;
            reg_write_o  = is_arith || is_arith_imm || is_load || is_jalr;
            mem_to_reg_o = is_load;
            retire       = 1'b1;
            state_d      = S_IF;
         end

         S_HALT: begin
            halted_o = 1'b1;
         end

         default: begin
            state_d = S_IF;
         end
      endcase

      // Strobes must fall the instant reset asserts, not at the next edge
      if (!rst_n_i) begin
         retire          = 1'b0;
         pc_write_o      = 1'b0;
         pc_write_cond_o = 1'b0;
         pc_source_o     = 1'b0;
         i_or_d_o        = 1'b0;
         mem_read_o      = 1'b0;
         mem_write_o     = 1'b0;
         ir_write_o      = 1'b0;
         mem_to_reg_o    = 1'b0;
         reg_write_o     = 1'b0;
         alu_src_a_o     = 1'b0;
         alu_src_b_o     = SRC_B_RS2;
         alu_op_o        = ALU_ADD;
         is_ecall_o      = 1'b0;
         halted_o        = 1'b0;
      end
   end

   assign instret_o = instret_q;

endmodule
